// File: rtl/execute_stage.sv
// Execute stage of the RV32I pipeline.
// Selects forwarded operands, runs the ALU, resolves beq and registers the
// results into the EX/MEM pipeline register.
// The branch decision and target go straight back to fetch without a register.
module execute_stage #(
    parameter int XLEN    = 32,
    parameter int REGADDR = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               regwriteE,
    input  logic               resultsrcE,
    input  logic               memwriteE,
    input  logic               branchE,
    input  logic               alusrcE,
    input  logic [2:0]         alucontrolE,
    input  logic [XLEN-1:0]    RD1E,
    input  logic [XLEN-1:0]    RD2E,
    input  logic [XLEN-1:0]    immextE,
    input  logic [XLEN-1:0]    pcE,
    input  logic [XLEN-1:0]    pcincr4E,
    input  logic [REGADDR-1:0] RDE,
    input  logic [1:0]         forwardAE,
    input  logic [1:0]         forwardBE,
    input  logic [XLEN-1:0]    aluresultM_f,
    input  logic [XLEN-1:0]    resultW,
    output logic               pcsrcE,
    output logic [XLEN-1:0]    pctargetE,
    output logic               regwriteM,
    output logic               resultsrcM,
    output logic               memwriteM,
    output logic [XLEN-1:0]    aluresultM,
    output logic [XLEN-1:0]    writedataM,
    output logic [REGADDR-1:0] RDM,
    output logic [XLEN-1:0]    pcincr4M
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_res;
    logic            zero;

    logic               regwrite_d,  regwrite_q;
    logic               resultsrc_d, resultsrc_q;
    logic               memwrite_d,  memwrite_q;
    logic [XLEN-1:0]    aluresult_d, aluresult_q;
    logic [XLEN-1:0]    writedata_d, writedata_q;
    logic [REGADDR-1:0] rd_d,        rd_q;
    logic [XLEN-1:0]    pcincr4_d,   pcincr4_q;

    // Operand forwarding; code 11 is unused by the hazard unit and falls back to the register file.
    always_comb begin
        src_a = RD1E;
        fwd_b = RD2E;
        case (forwardAE)
            2'b01:   src_a = resultW;
            2'b10:   src_a = aluresultM_f;
            default: src_a = RD1E;
        endcase
        case (forwardBE)
            2'b01:   fwd_b = resultW;
            2'b10:   fwd_b = aluresultM_f;
            default: fwd_b = RD2E;
        endcase
        src_b = alusrcE ? immextE : fwd_b;
    end

    // ALU; unassigned operation codes yield zero.
    always_comb begin
        alu_res = '0;
        case (alucontrolE)
            ALU_ADD: alu_res = src_a + src_b;
            ALU_SUB: alu_res = src_a - src_b;
            ALU_AND: alu_res = src_a & src_b;
            ALU_OR:  alu_res = src_a | src_b;
            ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_res = '0;
        endcase
    end

    assign zero      = (alu_res == '0);
    assign pcsrcE    = branchE & zero;
    assign pctargetE = pcE + immextE;

    // Next value of the EX/MEM register; store data is the forwarded B before the immediate mux.
    always_comb begin
        regwrite_d  = regwriteE;
        resultsrc_d = resultsrcE;
        memwrite_d  = memwriteE;
        aluresult_d = alu_res;
        writedata_d = fwd_b;
        rd_d        = RDE;
        pcincr4_d   = pcincr4E;
    end

    // EX/MEM register: loads every cycle, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_q  <= 1'b0;
            resultsrc_q <= 1'b0;
            memwrite_q  <= 1'b0;
            aluresult_q <= '0;
            writedata_q <= '0;
            rd_q        <= '0;
            pcincr4_q   <= '0;
        end else begin
            regwrite_q  <= regwrite_d;
            resultsrc_q <= resultsrc_d;
            memwrite_q  <= memwrite_d;
            aluresult_q <= aluresult_d;
            writedata_q <= writedata_d;
            rd_q        <= rd_d;
            pcincr4_q   <= pcincr4_d;
        end
    end

    assign regwriteM  = regwrite_q;
    assign resultsrcM = resultsrc_q;
    assign memwriteM  = memwrite_q;
    assign aluresultM = aluresult_q;
    assign writedataM = writedata_q;
    assign RDM        = rd_q;
    assign pcincr4M   = pcincr4_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed vectors push their expected EX/MEM
// contents into a queue; a monitor pops and compares one cycle later.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        regwriteE, resultsrcE, memwriteE, branchE, alusrcE;
    logic [2:0]  alucontrolE;
    logic [31:0] RD1E, RD2E, immextE, pcE, pcincr4E;
    logic [4:0]  RDE;
    logic [1:0]  forwardAE, forwardBE;
    logic [31:0] aluresultM_f, resultW;
    logic        pcsrcE;
    logic [31:0] pctargetE;
    logic        regwriteM, resultsrcM, memwriteM;
    logic [31:0] aluresultM, writedataM, pcincr4M;
    logic [4:0]  RDM;

    typedef struct {
        string       name;
        logic        rw;
        logic        rs;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    execute_stage #(.XLEN(32), .REGADDR(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .regwriteE(regwriteE), .resultsrcE(resultsrcE), .memwriteE(memwriteE),
        .branchE(branchE), .alusrcE(alusrcE), .alucontrolE(alucontrolE),
        .RD1E(RD1E), .RD2E(RD2E), .immextE(immextE), .pcE(pcE), .pcincr4E(pcincr4E),
        .RDE(RDE), .forwardAE(forwardAE), .forwardBE(forwardBE),
        .aluresultM_f(aluresultM_f), .resultW(resultW),
        .pcsrcE(pcsrcE), .pctargetE(pctargetE),
        .regwriteM(regwriteM), .resultsrcM(resultsrcM), .memwriteM(memwriteM),
        .aluresultM(aluresultM), .writedataM(writedataM), .RDM(RDM), .pcincr4M(pcincr4M)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    task automatic check_m_zero(input string tag);
        chk({tag, " regwriteM"},  {31'd0, regwriteM},  32'd0);
        chk({tag, " resultsrcM"}, {31'd0, resultsrcM}, 32'd0);
        chk({tag, " memwriteM"},  {31'd0, memwriteM},  32'd0);
        chk({tag, " aluresultM"}, aluresultM,          32'd0);
        chk({tag, " writedataM"}, writedataM,          32'd0);
        chk({tag, " RDM"},        {27'd0, RDM},        32'd0);
        chk({tag, " pcincr4M"},   pcincr4M,            32'd0);
    endtask

    // Called just after a negedge: drives one instruction, checks the
    // combinational branch outputs, queues the registered result.
    task automatic issue(input string nm,
                         input logic rw, input logic rs, input logic mw,
                         input logic br, input logic as, input logic [2:0] ctrl,
                         input logic [1:0] fa, input logic [1:0] fb,
                         input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [31:0] fm, input logic [31:0] fw,
                         input logic [4:0] rd,
                         input logic [31:0] e_alu, input logic [31:0] e_wd,
                         input logic e_pcsrc, input logic [31:0] e_tgt);
        exp_t e;
        regwriteE = rw; resultsrcE = rs; memwriteE = mw; branchE = br; alusrcE = as;
        alucontrolE = ctrl; forwardAE = fa; forwardBE = fb;
        RD1E = rd1; RD2E = rd2; immextE = imm; pcE = pc; pcincr4E = pc + 32'd4;
        aluresultM_f = fm; resultW = fw; RDE = rd;
        e.name = nm; e.rw = rw; e.rs = rs; e.mw = mw;
        e.alu = e_alu; e.wd = e_wd; e.rd = rd; e.pc4 = pc + 32'd4;
        exp_q.push_back(e);
        #1;
        chk({nm, " pcsrcE"},    {31'd0, pcsrcE}, {31'd0, e_pcsrc});
        chk({nm, " pctargetE"}, pctargetE,       e_tgt);
        @(negedge clk);
    endtask

    // Monitor: each queued instruction is compared one posedge after issue.
    always @(posedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            #1;
            chk({e.name, " regwriteM"},  {31'd0, regwriteM},  {31'd0, e.rw});
            chk({e.name, " resultsrcM"}, {31'd0, resultsrcM}, {31'd0, e.rs});
            chk({e.name, " memwriteM"},  {31'd0, memwriteM},  {31'd0, e.mw});
            chk({e.name, " aluresultM"}, aluresultM,          e.alu);
            chk({e.name, " writedataM"}, writedataM,          e.wd);
            chk({e.name, " RDM"},        {27'd0, RDM},        {27'd0, e.rd});
            chk({e.name, " pcincr4M"},   pcincr4M,            e.pc4);
        end
    end

    initial begin
        rst_n = 1'b0;
        regwriteE = 0; resultsrcE = 0; memwriteE = 0; branchE = 0; alusrcE = 0;
        alucontrolE = 3'b000; forwardAE = 2'b00; forwardBE = 2'b00;
        RD1E = 0; RD2E = 0; immextE = 0; pcE = 0; pcincr4E = 0;
        aluresultM_f = 0; resultW = 0; RDE = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_m_zero("reset");
        rst_n = 1'b1;

        //    name         rw rs mw br as ctrl    fa     fb     rd1           rd2           imm           pc            fwdM          fwdW          rd     alu           wd            pcsrc tgt
        issue("add",       1, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 32'd5,        32'd7,        32'd0,        32'h100,      32'd0,        32'd0,        5'd3,  32'd12,       32'd7,        0, 32'h100);
        issue("fwd_store", 0, 0, 1, 0, 1, 3'b000, 2'b10, 2'b01, 32'd1,        32'h99,       32'd4,        32'h104,      32'h10,       32'h20,       5'd0,  32'h14,       32'h20,       0, 32'h108);
        issue("slt_neg",   1, 0, 0, 0, 0, 3'b101, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h108,      32'd0,        32'd0,        5'd4,  32'd1,        32'd1,        0, 32'h108);
        issue("slt_swap",  1, 0, 0, 0, 0, 3'b101, 2'b00, 2'b00, 32'd1,        32'hFFFFFFFF, 32'd0,        32'h10C,      32'd0,        32'd0,        5'd5,  32'd0,        32'hFFFFFFFF, 0, 32'h10C);
        issue("sub_0m1",   1, 0, 0, 0, 0, 3'b001, 2'b00, 2'b00, 32'd0,        32'd1,        32'd0,        32'h110,      32'd0,        32'd0,        5'd6,  32'hFFFFFFFF, 32'd1,        0, 32'h110);
        issue("beq_take",  0, 0, 0, 1, 0, 3'b001, 2'b00, 2'b00, 32'd9,        32'd9,        32'hFFFFFFF8, 32'h100,      32'd0,        32'd0,        5'd0,  32'd0,        32'd9,        1, 32'hF8);
        issue("beq_not",   0, 0, 0, 1, 0, 3'b001, 2'b00, 2'b00, 32'd9,        32'd8,        32'hFFFFFFF8, 32'h100,      32'd0,        32'd0,        5'd0,  32'd1,        32'd8,        0, 32'hF8);
        issue("ctrl111",   1, 0, 0, 0, 0, 3'b111, 2'b00, 2'b00, 32'd5,        32'd7,        32'd0,        32'h118,      32'd0,        32'd0,        5'd7,  32'd0,        32'd7,        0, 32'h118);
        issue("and",       1, 0, 0, 0, 0, 3'b010, 2'b00, 2'b00, 32'h0000F0F0, 32'h0000FF00, 32'd0,        32'h11C,      32'd0,        32'd0,        5'd8,  32'h0000F000, 32'h0000FF00, 0, 32'h11C);
        issue("or_fwd11",  1, 1, 0, 0, 0, 3'b011, 2'b11, 2'b11, 32'h0000F0F0, 32'h0000FF00, 32'd0,        32'h120,      32'hDEAD,     32'hBEEF,     5'd9,  32'h0000FFF0, 32'h0000FF00, 0, 32'h120);
        issue("add_wrap",  1, 0, 0, 0, 0, 3'b000, 2'b01, 2'b10, 32'd0,        32'd0,        32'd0,        32'hFFFFFFFC, 32'd2,        32'hFFFFFFFF, 5'd31, 32'd1,        32'd2,        0, 32'hFFFFFFFC);
        issue("beq_fwdA",  0, 0, 0, 1, 0, 3'b001, 2'b01, 2'b00, 32'd3,        32'h55,       32'h10,       32'h200,      32'd0,        32'h55,       5'd0,  32'd0,        32'h55,       1, 32'h210);
        issue("bubble",    0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 32'd0,        32'd0,        32'd0,        32'd0,        32'd0,        32'd0,        5'd0,  32'd0,        32'd0,        0, 32'd0);

        // Mid-stream reset: load a live instruction, then present another and
        // pull reset before it is captured.
        issue("pre_rst",   1, 1, 1, 0, 0, 3'b000, 2'b00, 2'b00, 32'd40,       32'd2,        32'd0,        32'h300,      32'd0,        32'd0,        5'd12, 32'd42,       32'd2,        0, 32'h300);
        @(negedge clk);
        regwriteE = 1; memwriteE = 1; branchE = 1; alucontrolE = 3'b001;
        RD1E = 32'd6; RD2E = 32'd6; pcE = 32'h400; immextE = 32'h20; pcincr4E = 32'h404; RDE = 5'd13;
        #2;
        rst_n = 1'b0;
        #1;
        check_m_zero("async_rst");
        chk("rst pcsrcE",    {31'd0, pcsrcE}, 32'd1);
        chk("rst pctargetE", pctargetE,       32'h420);
        RD2E = 32'd7; immextE = 32'h40;
        #1;
        chk("rst pcsrcE follow",    {31'd0, pcsrcE}, 32'd0);
        chk("rst pctargetE follow", pctargetE,       32'h440);
        @(negedge clk);
        check_m_zero("rst_held");
        rst_n = 1'b1;
        issue("post_rst",  1, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 32'd100,      32'd23,       32'd0,        32'h500,      32'd0,        32'd0,        5'd14, 32'd123,      32'd23,       0, 32'h500);

        repeat (3) @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
